start_pulse_scheduler: RTL
==========================

Name: start_pulse_scheduler

Overview:
- Shares one `start` line between NREQ requesters.
- Each accepted request drives `start` high for a requested number of clock cycles.
- After the high phase, `start` is forced low for GAP cycles so every pulse has a detectable rising edge.
- At the end of each pulse the block reports the high-cycle count it actually produced. Downstream pulse-width checkers and benches measure against that count.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LEN_W, 5, width of a requested pulse length.
- GAP, 1, minimum low cycles between pulses (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request.
- req_len  input  NREQ*LEN_W  per-requester length; slice i is bits [i*LEN_W +: LEN_W].
- req_ready  output  NREQ  one-hot accept strobe.
- start  output  1  shared start line, registered.
- busy  output  1  high in HIGH or GAP state.
- grant_id  output  $clog2(NREQ)  index of the current or last owner.
- done_valid  output  1  one-cycle completion pulse.
- done_id  output  $clog2(NREQ)  owner of the completed pulse.
- done_count  output  LEN_W  number of cycles `start` was high.

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - state=IDLE, start=0, busy=0, req_ready=0.
  - grant_id=0, done_valid=0, done_id=0, done_count=0.
  - Round-robin pointer=0.
- States: IDLE, HIGH, GAP.
- IDLE:
  - If any req_valid, the round-robin arbiter picks the winner: the first set bit at or after the pointer, wrapping around.
  - req_ready[winner] is combinational, asserted the same cycle; a handshake is valid&ready.
  - On handshake: latch len (0 clamped to 1), grant_id<=winner, pointer<=winner+1 mod NREQ, cnt<=0.
  - Next state is HIGH; start=1 from the next cycle.
- HIGH:
  - start=1, cnt increments each cycle.
  - When cnt==len-1 on a cycle: next cycle start=0, state=GAP, done_valid=1.
  - done_count = cnt+1, which equals len; done_id=grant_id.
  - req_ready=0 throughout.
- GAP:
  - start=0 for exactly GAP cycles, then IDLE.
  - A new grant can occur in the IDLE cycle that follows.
  - Back-to-back requests therefore see start low for GAP+1 cycles minimum.
- Latency: handshake in cycle T -> start high T+1..T+len -> done_valid at T+len+1.
- Request rules:
  - req_len and req_valid are sampled only at handshake.
  - Changes while busy are ignored.
  - Deasserting req_valid before a grant is legal.
- Width rules:
  - Maximum length is 2**LEN_W-1; cnt is LEN_W bits wide and never wraps.
- Simultaneous requests: the round-robin order guarantees no requester waits more than NREQ-1 grants.
- Reset mid-pulse: start drops to 0 immediately (async), no done_valid is issued, and the pointer returns to 0.

Optional Feature:
- START_SVA_EN defined:
  - Embedded concurrent assertions. On $rose(start), a local-variable counter increments while start is high.
  - On start falling, they check that the count equals done_count and that done_valid is high in the same cycle.
  - $onehot0(req_ready) is checked.
  - start is checked low for >=GAP cycles after each fall.
  - $info on pass, $error on fail.
- START_SVA_EN undefined: no assertion code is compiled; RTL behaviour is identical.

Decomposition:
- Package start_sched_pkg holds:
  - typedef enum logic[1:0] {IDLE, HIGH, GAP} sched_state_t;
  - the default parameter constants;
  - a function clamp_len().
- Sub-module rr_arbiter (parameter NREQ):
  - Inputs: req, ptr. Output: one-hot gnt plus an encoded index.
  - Purely combinational.
  - The pointer register stays in the parent.

Test Plan:
- Single pulse: req_valid[0]=1, len=12 -> start high exactly 12 cycles; done_valid one cycle after the fall; done_count=12, done_id=0.
- Contention: both requesters valid, len0=3, len1=5, held -> grant order 0,1,0,1; start pattern 3 high, GAP+1 low, 5 high, ...; done_ids alternate.
- Zero length: len=0 -> start high 1 cycle, done_count=1.
- Maximum length with LEN_W=5: len=31 -> 31 high cycles, done_count=31, no wrap.
- Reset mid-pulse: rst_n low at cycle 4 of len=10 -> start=0 immediately; no done_valid; after release, requester 0 is granted first.
- Ignored update: req_len changed from 6 to 2 during HIGH -> pulse still 6 cycles.

Source files
------------

// File: rtl/start_pulse_scheduler_pkg.sv
// Shared types, default parameters and helpers for start_pulse_scheduler.
package start_sched_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, GAP = 2'd2} sched_state_t;

    localparam int DEF_NREQ  = 2;
    localparam int DEF_LEN_W = 5;
    localparam int DEF_GAP   = 1;

    // A zero-length request still produces a visible one-cycle pulse.
    function automatic logic [31:0] clamp_len(input logic [31:0] len);
        return (len == 32'd0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/start_pulse_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx
);
    localparam int IDX_W = $clog2(NREQ);

    always_comb begin
        int  pos;
        logic found;
        gnt   = '0;
        idx   = '0;
        pos   = 0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/start_pulse_scheduler.sv
// Shared start-line pulse scheduler with round-robin arbitration and width report.
// Define START_SVA_EN to compile embedded pulse-width/gap/one-hot assertions.
module start_pulse_scheduler
    import start_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int LEN_W = DEF_LEN_W,
    parameter int GAP   = DEF_GAP
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*LEN_W-1:0]   req_len,
    output logic [NREQ-1:0]         req_ready,
    output logic                    start,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    done_valid,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [LEN_W-1:0]        done_count
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    logic [LEN_W-1:0] len_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
            assign len_arr[gi] = req_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    sched_state_t     state_reg, state_next;
    logic             start_reg, start_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [IDX_W-1:0] grant_reg, grant_next;
    logic             done_valid_reg, done_valid_next;
    logic [IDX_W-1:0] done_id_reg, done_id_next;
    logic [LEN_W-1:0] done_count_reg, done_count_next;
    logic [NREQ-1:0]  win_gnt;
    logic [IDX_W-1:0] win_idx;
    logic             handshake;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_reg),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    assign req_ready = (rst_n && state_reg == IDLE) ? win_gnt : '0;
    assign handshake = |req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            start_reg      <= 1'b0;
            len_reg        <= '0;
            cnt_reg        <= '0;
            gap_cnt_reg    <= '0;
            ptr_reg        <= '0;
            grant_reg      <= '0;
            done_valid_reg <= 1'b0;
            done_id_reg    <= '0;
            done_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            start_reg      <= start_next;
            len_reg        <= len_next;
            cnt_reg        <= cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            ptr_reg        <= ptr_next;
            grant_reg      <= grant_next;
            done_valid_reg <= done_valid_next;
            done_id_reg    <= done_id_next;
            done_count_reg <= done_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        start_next      = start_reg;
        len_next        = len_reg;
        cnt_next        = cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        ptr_next        = ptr_reg;
        grant_next      = grant_reg;
        done_valid_next = 1'b0;
        done_id_next    = done_id_reg;
        done_count_next = done_count_reg;
        case (state_reg)
            IDLE: begin
                if (handshake) begin
                    len_next   = LEN_W'(clamp_len(32'(len_arr[win_idx])));
                    grant_next = win_idx;
                    ptr_next   = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    cnt_next   = '0;
                    start_next = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                // cnt stops at len-1, so it never wraps even at the maximum length.
                if (cnt_reg == len_reg - LEN_W'(1)) begin
                    start_next      = 1'b0;
                    state_next      = start_sched_pkg::GAP;
                    done_valid_next = 1'b1;
                    done_id_next    = grant_reg;
                    done_count_next = cnt_reg + LEN_W'(1);
                    gap_cnt_next    = '0;
                end else begin
                    cnt_next = cnt_reg + LEN_W'(1);
                end
            end
            start_sched_pkg::GAP: begin
                if (gap_cnt_reg == GAP_W'(GAP - 1)) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign start      = start_reg;
    assign busy       = (state_reg != IDLE);
    assign grant_id   = grant_reg;
    assign done_valid = done_valid_reg;
    assign done_id    = done_id_reg;
    assign done_count = done_count_reg;

`ifdef START_SVA_EN
    property p_width;
        int n;
        @(posedge clk) disable iff (!rst_n)
        ($rose(start), n = 1) ##1 (start, n = n + 1)[*0:$] ##1 !start
        |-> done_valid && (int'(done_count) == n);
    endproperty

    a_width: assert property (p_width)
        $info("start pulse width matches done_count");
    else
        $error("start pulse width differs from done_count");

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready))
        $info("req_ready one-hot");
    else
        $error("req_ready not one-hot");

    a_gap: assert property (@(posedge clk) disable iff (!rst_n) $fell(start) |-> !start[*GAP])
        $info("start low gap respected");
    else
        $error("start low gap too short");
`else
`endif

endmodule
